comb_vector_checker: RTL and testbench
======================================

# comb_vector_checker

Synthesizable response checker for combinational blocks: it receives DUT outputs together with their expected values over a valid/ready stream and reports the verdict. It compares each beat, counts vectors and mismatches, and captures the first failing vector. It also compacts every DUT output into a 16-bit MISR signature. It is the receiving end of the stimulus path and lets the existing vector-driven checks run on hardware or in a self-checking top level.

## Interface
- W, 4, width of one DUT result (1..16)
- NVEC, 256, number of vectors in a complete run (1..65535)
- STOP_ON_FAIL, 0, 1 = end the run on the first mismatching beat

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run (sampled in IDLE or DONE only)
- in_valid  in  1  y/yeta beat present
- in_ready  out  1  checker accepts a beat
- y  in  W  DUT output
- yeta  in  W  expected output
- busy  out  1  run in progress
- done  out  1  run finished, results stable
- pass  out  1  done && fail_cnt == 0
- vec_cnt  out  16  beats accepted this run
- fail_cnt  out  16  mismatching beats this run (saturates at 16'hFFFF)
- first_fail_idx  out  16  vec_cnt value of the first mismatch
- first_fail_y  out  W  y of the first mismatch
- first_fail_yeta  out  W  yeta of the first mismatch
- signature  out  16  MISR over all accepted y

## Operation
- States are IDLE, RUN and DONE, held in a registered state.
- IDLE -> RUN when start = 1. On that edge vec_cnt, fail_cnt and all first_fail_* clear to 0, and signature is set to 16'hFFFF.
- RUN: in_ready = 1. A beat is accepted on a posedge with in_valid && in_ready.
  - On each accepted beat, vec_cnt increments by 1.
  - Mismatch means y != yeta (bitwise, all W bits). On a mismatch fail_cnt increments. If fail_cnt was 0, first_fail_idx takes the pre-increment vec_cnt and first_fail_y/yeta capture y/yeta.
  - On each accepted beat: signature <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended y.
- RUN -> DONE on the beat that makes vec_cnt == NVEC. When STOP_ON_FAIL = 1, RUN also exits to DONE on any mismatching beat.
- DONE holds all result outputs stable with in_ready = 0. start = 1 in DONE -> RUN with the same clearing as from IDLE.
- start while in RUN is ignored.
- in_valid outside RUN is ignored; no beat is counted.
- busy = (state == RUN). done = (state == DONE).

## Timing
- Reset (async, rst_n = 0) forces the following immediately, independent of clk:
  - state IDLE, in_ready 0, busy 0, done 0, pass 0
  - vec_cnt, fail_cnt, first_fail_idx, first_fail_y, first_fail_yeta all 0
  - signature 16'hFFFF
- Reset mid-run abandons the run; a fresh start is required.
- start sampled at edge N: busy = 1 and in_ready = 1 from edge N. The earliest beat is accepted at edge N+1.
- in_ready is a function of registered state only; it has no combinational path from in_valid or start.
- Final beat accepted at edge M: done = 1, busy = 0 and in_ready = 0 from edge M. All counters already reflect beat M.
- Maximum throughput is one beat per cycle. Gaps in in_valid stall the run indefinitely; there is no timeout.
- fail_cnt saturates at 16'hFFFF and vec_cnt never exceeds NVEC.
- The signature covers y only, never yeta.

## Test plan
- All-match run (W=4, NVEC=256, STOP_ON_FAIL=0), 256 back-to-back beats with y == yeta -> done after beat 256, vec_cnt=256, fail_cnt=0, pass=1, first_fail_* = 0.
- Single mismatch at index 5 (y=4'b1010, yeta=4'b1011), all other beats matching -> vec_cnt=256, fail_cnt=1, first_fail_idx=5, first_fail_y=4'b1010, first_fail_yeta=4'b1011, pass=0.
- STOP_ON_FAIL=1 with a mismatch at index 3 -> done on the edge accepting beat 3, vec_cnt=4, fail_cnt=1, in_ready=0 afterwards, further in_valid not counted.
- in_valid asserted only on alternate cycles over a 256-vector all-match run -> identical results to the back-to-back run, 511 cycles from first to last beat.
- Signature check (NVEC=4), y = 1, 2, 3, 4 -> signature sequence EFDE, CF9F, 8F1C, 0E1D; final signature 16'h0E1D.
- Reset after 100 accepted beats -> all outputs at reset values immediately. A new start plus 256 beats then gives vec_cnt=256, with no carry-over from the aborted run.

Source files
------------

// File: rtl/comb_vector_checker.sv
// comb_vector_checker: receiving end of a vector-driven check of a combinational
// block. Compares each accepted y/yeta beat, counts vectors and mismatches,
// captures the first failing vector and compacts every y into a 16-bit MISR.
module comb_vector_checker #(
    parameter int W            = 4,
    parameter int NVEC         = 256,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  y,
    input  logic [W-1:0]  yeta,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   vec_cnt,
    output logic [15:0]   fail_cnt,
    output logic [15:0]   first_fail_idx,
    output logic [W-1:0]  first_fail_y,
    output logic [W-1:0]  first_fail_yeta,
    output logic [15:0]   signature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] NVEC16    = 16'(NVEC);
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] SIG_SEED  = 16'hFFFF;

    state_t      state;
    logic        mismatch;
    logic        last_beat;
    logic        stop_now;
    logic [15:0] vec_nxt;
    logic [15:0] sig_nxt;

    // Per-beat next values: mismatch flag, next vector count and next MISR state
    always_comb begin
        mismatch  = (y != yeta);
        vec_nxt   = vec_cnt + 16'd1;
        last_beat = (vec_nxt == NVEC16);
        stop_now  = (STOP_ON_FAIL != 0) && mismatch;
        sig_nxt   = {signature[14:0], 1'b0}
                  ^ (signature[15] ? MISR_POLY : '0)
                  ^ 16'(y);
    end

    // Run control, counters, first-fail capture and signature
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            vec_cnt         <= '0;
            fail_cnt        <= '0;
            first_fail_idx  <= '0;
            first_fail_y    <= '0;
            first_fail_yeta <= '0;
            signature       <= SIG_SEED;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= RUN;
                        vec_cnt         <= '0;
                        fail_cnt        <= '0;
                        first_fail_idx  <= '0;
                        first_fail_y    <= '0;
                        first_fail_yeta <= '0;
                        signature       <= SIG_SEED;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        vec_cnt   <= vec_nxt;
                        signature <= sig_nxt;
                        if (mismatch) begin
                            if (fail_cnt != 16'hFFFF) begin
                                fail_cnt <= fail_cnt + 16'd1;
                            end
                            if (fail_cnt == '0) begin
                                first_fail_idx  <= vec_cnt;
                                first_fail_y    <= y;
                                first_fail_yeta <= yeta;
                            end
                        end
                        if (last_beat || stop_now) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status outputs depend on registered state only
    always_comb begin
        in_ready = (state == RUN);
        busy     = (state == RUN);
        done     = (state == DONE);
        pass     = (state == DONE) && (fail_cnt == '0);
    end

endmodule

// File: tb/tb_comb_vector_checker.sv
// Bench for comb_vector_checker: three instances share clock, reset and the
// beat inputs. dut_a (defaults) is tracked by a scoreboard model; dut_s
// (STOP_ON_FAIL=1) and dut_n (NVEC=4) are checked against directed constants.
module tb_comb_vector_checker;

    logic       clk;
    logic       rst_n;
    logic       start_a, start_s, start_n;
    logic       in_valid;
    logic [3:0] y, yeta;

    logic        rdy_a, busy_a, done_a, pass_a;
    logic [15:0] vec_a, fail_a, ffi_a, sig_a;
    logic [3:0]  ffy_a, ffe_a;

    logic        rdy_s, busy_s, done_s, pass_s;
    logic [15:0] vec_s, fail_s, ffi_s, sig_s;
    logic [3:0]  ffy_s, ffe_s;

    logic        rdy_n, busy_n, done_n, pass_n;
    logic [15:0] vec_n, fail_n, ffi_n, sig_n;
    logic [3:0]  ffy_n, ffe_n;

    comb_vector_checker #(.W(4), .NVEC(256), .STOP_ON_FAIL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid),
        .in_ready(rdy_a), .y(y), .yeta(yeta), .busy(busy_a), .done(done_a),
        .pass(pass_a), .vec_cnt(vec_a), .fail_cnt(fail_a),
        .first_fail_idx(ffi_a), .first_fail_y(ffy_a), .first_fail_yeta(ffe_a),
        .signature(sig_a)
    );

    comb_vector_checker #(.W(4), .NVEC(256), .STOP_ON_FAIL(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(in_valid),
        .in_ready(rdy_s), .y(y), .yeta(yeta), .busy(busy_s), .done(done_s),
        .pass(pass_s), .vec_cnt(vec_s), .fail_cnt(fail_s),
        .first_fail_idx(ffi_s), .first_fail_y(ffy_s), .first_fail_yeta(ffe_s),
        .signature(sig_s)
    );

    comb_vector_checker #(.W(4), .NVEC(4), .STOP_ON_FAIL(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start_n), .in_valid(in_valid),
        .in_ready(rdy_n), .y(y), .yeta(yeta), .busy(busy_n), .done(done_n),
        .pass(pass_n), .vec_cnt(vec_n), .fail_cnt(fail_n),
        .first_fail_idx(ffi_n), .first_fail_y(ffy_n), .first_fail_yeta(ffe_n),
        .signature(sig_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        logic [15:0] vec;
        logic [15:0] fail;
        logic [15:0] sig;
    } exp_t;
    exp_t sb[$];

    // Reference model of dut_a
    bit          m_run;
    logic [15:0] m_vec, m_fail, m_sig, m_ffi;
    logic [3:0]  m_ffy, m_ffe;
    int          last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [3:0] v);
        logic [15:0] r;
        r = {s[14:0], 1'b0};
        if (s[15]) r = r ^ 16'h1021;
        return r ^ {12'h000, v};
    endfunction

    task automatic model_clear();
        m_vec = '0; m_fail = '0; m_ffi = '0; m_ffy = '0; m_ffe = '0;
        m_sig = 16'hFFFF;
    endtask

    task automatic start_a_run();
        start_a = 1'b1;
        if (!m_run) begin
            model_clear();
            m_run = 1'b1;
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("a_busy_after_start", busy_a, 1);
        chk("a_rdy_after_start", rdy_a, 1);
    endtask

    task automatic beat(input logic [3:0] by, input logic [3:0] be);
        exp_t e;
        bit   pushed;
        pushed   = 1'b0;
        in_valid = 1'b1;
        y        = by;
        yeta     = be;
        chk("a_rdy", rdy_a, {31'd0, m_run});
        if (m_run) begin
            if (by != be) begin
                if (m_fail == '0) begin
                    m_ffi = m_vec; m_ffy = by; m_ffe = be;
                end
                if (m_fail != 16'hFFFF) m_fail = m_fail + 16'd1;
            end
            m_vec = m_vec + 16'd1;
            m_sig = misr(m_sig, by);
            if (m_vec == 16'd256) m_run = 1'b0;
            e.vec = m_vec; e.fail = m_fail; e.sig = m_sig;
            sb.push_back(e);
            pushed = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        last_acc = cyc;
        if (pushed) begin
            e = sb.pop_front();
            chk("a_vec", vec_a, e.vec);
            chk("a_fail", fail_a, e.fail);
            chk("a_sig", sig_a, e.sig);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic a_final(input logic expect_done);
        chk("a_done", done_a, {31'd0, expect_done});
        chk("a_busy", busy_a, {31'd0, ~expect_done});
        chk("a_pass", pass_a, {31'd0, expect_done && (m_fail == 0)});
        chk("a_vec_final", vec_a, m_vec);
        chk("a_fail_final", fail_a, m_fail);
        chk("a_ffi", ffi_a, m_ffi);
        chk("a_ffy", ffy_a, m_ffy);
        chk("a_ffe", ffe_a, m_ffe);
        chk("a_sig_final", sig_a, m_sig);
    endtask

    task automatic a_reset_vals();
        chk("rst_rdy", rdy_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_vec", vec_a, 0);
        chk("rst_fail", fail_a, 0);
        chk("rst_ffi", ffi_a, 0);
        chk("rst_ffy", ffy_a, 0);
        chk("rst_ffe", ffe_a, 0);
        chk("rst_sig", sig_a, 16'hFFFF);
    endtask

    initial begin
        logic [3:0]  r;
        logic [15:0] sig_tab [4];
        int          first_acc;

        sig_tab[0] = 16'hEFDE; sig_tab[1] = 16'hCF9F;
        sig_tab[2] = 16'h8F1C; sig_tab[3] = 16'h0E1D;

        rst_n = 1'b0; start_a = 0; start_s = 0; start_n = 0;
        in_valid = 0; y = '0; yeta = '0;
        m_run = 1'b0; model_clear(); last_acc = 0;
        #12;
        a_reset_vals();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // beat while idle is ignored everywhere
        beat(4'h3, 4'h5);
        chk("idle_vec_a", vec_a, 0);
        chk("idle_fail_a", fail_a, 0);
        chk("idle_vec_s", vec_s, 0);

        // signature sequence on the NVEC=4 instance
        start_n = 1'b1; @(posedge clk); #1; start_n = 1'b0;
        chk("n_rdy", rdy_n, 1);
        chk("n_sig_seed", sig_n, 16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            r = 4'(i + 1);
            beat(r, r);
            chk($sformatf("n_sig%0d", i), sig_n, sig_tab[i]);
        end
        chk("n_done", done_n, 1);
        chk("n_pass", pass_n, 1);
        chk("n_vec", vec_n, 4);
        chk("n_rdy_done", rdy_n, 0);
        beat(4'h7, 4'h7);
        chk("n_vec_hold", vec_n, 4);
        chk("n_sig_hold", sig_n, 16'h0E1D);

        // stop-on-fail at index 3
        start_s = 1'b1; @(posedge clk); #1; start_s = 1'b0;
        beat(4'h1, 4'h1); beat(4'h2, 4'h2); beat(4'h3, 4'h3);
        chk("s_busy_mid", busy_s, 1);
        beat(4'h9, 4'h8);
        chk("s_done", done_s, 1);
        chk("s_vec", vec_s, 4);
        chk("s_fail", fail_s, 1);
        chk("s_ffi", ffi_s, 3);
        chk("s_ffy", ffy_s, 4'h9);
        chk("s_ffe", ffe_s, 4'h8);
        chk("s_pass", pass_s, 0);
        chk("s_rdy", rdy_s, 0);
        beat(4'h0, 4'h1); beat(4'h2, 4'h2);
        chk("s_vec_hold", vec_s, 4);
        chk("s_fail_hold", fail_s, 1);

        // all-match back-to-back run, with a start pulse mid-run that must be ignored
        start_a_run();
        for (int i = 0; i < 256; i++) begin
            r = 4'($urandom_range(0, 15));
            if (i == 10) start_a = 1'b1;
            beat(r, r);
            start_a = 1'b0;
            if (i == 254) chk("a_busy_before_last", busy_a, 1);
        end
        a_final(1'b1);
        chk("a_rdy_done", rdy_a, 0);
        beat(4'h1, 4'h2);
        chk("a_vec_done_hold", vec_a, 256);
        chk("a_fail_done_hold", fail_a, 0);

        // restart from DONE: single mismatch at index 5, then another later
        start_a_run();
        chk("a_restart_vec", vec_a, 0);
        chk("a_restart_sig", sig_a, 16'hFFFF);
        for (int i = 0; i < 256; i++) begin
            r = 4'($urandom_range(0, 15));
            if (i == 5) beat(4'b1010, 4'b1011);
            else if (i == 200) beat(4'b0001, 4'b0000);
            else beat(r, r);
        end
        a_final(1'b1);

        // alternate-cycle all-match run
        start_a_run();
        first_acc = 0;
        for (int i = 0; i < 256; i++) begin
            r = 4'($urandom_range(0, 15));
            beat(r, r);
            if (i == 0) first_acc = last_acc;
            if (i != 255) idle_cycle();
        end
        a_final(1'b1);
        chk("a_alt_span", 32'(last_acc - first_acc + 1), 511);

        // reset mid-run after 100 beats, then a fresh full run
        start_a_run();
        for (int i = 0; i < 100; i++) begin
            r = 4'($urandom_range(0, 15));
            beat(r, 4'(r ^ {3'b000, (i % 7 == 0) ? 1'b1 : 1'b0}));
        end
        chk("a_vec_100", vec_a, 100);
        #2 rst_n = 1'b0;
        #1;
        a_reset_vals();
        chk("rst_done_s", done_s, 0);
        chk("rst_vec_n", vec_n, 0);
        m_run = 1'b0; model_clear(); sb.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("a_idle_after_rst", busy_a, 0);
        start_a_run();
        for (int i = 0; i < 256; i++) begin
            r = 4'($urandom_range(0, 15));
            beat(r, r);
        end
        a_final(1'b1);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
